// File: rtl/pos_cell_reader.sv
// Streaming read controller for one position cell memory: reads the particle count
// at address 0, then streams particles 1..N through a credit-controlled skid FIFO.
module pos_cell_reader #(
    parameter int unsigned DATA_WIDTH   = 96,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned PARTICLE_NUM = 220,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] cell_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last,
    output logic                  done
);

    localparam int unsigned BUF_DEPTH = FIFO_DEPTH - 1;
    localparam int unsigned PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W     = CNT_W + 2;
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pid;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_REQ,
        S_CNT_WAIT,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ram_address, w_addr_nxt;
    logic                  r_ram_rden, w_rden_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [ADDR_WIDTH-1:0] r_cell_count, w_count_nxt;
    logic                  r_done, w_done_nxt;
    logic [ADDR_WIDTH-1:0] r_next_addr, w_next_addr_nxt;
    logic [1:0]            r_inflight;
    logic                  r_rd_d1, r_rd_d2;
    logic [ADDR_WIDTH-1:0] r_pid_d1, r_pid_d2;

    beat_t                 r_head;
    logic                  r_head_valid;
    logic                  r_head_last;
    beat_t                 r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_buf_count;

    logic                  w_push, w_pop, w_head_load, w_buf_push, w_buf_pop;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [ADDR_WIDTH-1:0] w_raw_count, w_clamped;
    logic                  w_credit_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Head register is the visible FIFO slot; the buffer behind it holds the rest.
    assign w_push       = r_rd_d2 && (r_pid_d2 != '0);
    assign w_pop        = r_head_valid && out_ready;
    assign w_head_load  = !r_head_valid || w_pop;
    assign w_buf_pop    = w_head_load && (r_buf_count != '0);
    assign w_buf_push   = w_push && !(w_head_load && (r_buf_count == '0));
    assign w_fifo_count = r_buf_count + CNT_W'(r_head_valid);

    assign w_raw_count  = ram_q[ADDR_WIDTH-1:0];
    assign w_clamped    = (w_raw_count > MAX_COUNT) ? MAX_COUNT : w_raw_count;

    // A beat popped this cycle frees a slot for the read issued now.
    assign w_credit_ok  = (CRD_W'(r_inflight) + CRD_W'(r_ram_rden) + CRD_W'(w_fifo_count) + CRD_W'(1))
                          <= (CRD_W'(FIFO_DEPTH) + CRD_W'(w_pop));

    always_comb begin
        w_state_nxt     = r_state;
        w_rden_nxt      = 1'b0;
        w_addr_nxt      = r_ram_address;
        w_next_addr_nxt = r_next_addr;
        w_count_nxt     = r_cell_count;
        w_done_nxt      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !r_busy) begin
                    w_state_nxt = S_CNT_REQ;
                    w_rden_nxt  = 1'b1;
                    w_addr_nxt  = '0;
                end
            end
            S_CNT_REQ: begin
                w_state_nxt = S_CNT_WAIT;
            end
            S_CNT_WAIT: begin
                if (r_rd_d2) begin
                    w_count_nxt = w_clamped;
                    if (w_clamped == '0) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_rden_nxt      = 1'b1;
                        w_addr_nxt      = ADDR_WIDTH'(1);
                        w_next_addr_nxt = ADDR_WIDTH'(2);
                        w_state_nxt     = (w_clamped == ADDR_WIDTH'(1)) ? S_DRAIN : S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (w_credit_ok) begin
                    w_rden_nxt      = 1'b1;
                    w_addr_nxt      = r_next_addr;
                    w_next_addr_nxt = r_next_addr + 1'b1;
                    if (r_next_addr == r_cell_count) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((r_inflight == '0) && !r_ram_rden &&
                    ((w_fifo_count == '0) || ((w_fifo_count == CNT_W'(1)) && w_pop))) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Busy stays up through the done cycle so a restart lands one cycle later.
        w_busy_nxt = (w_state_nxt != S_IDLE) || w_done_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ram_address <= '0;
            r_ram_rden    <= 1'b0;
            r_busy        <= 1'b0;
            r_cell_count  <= '0;
            r_done        <= 1'b0;
            r_next_addr   <= '0;
            r_inflight    <= '0;
            r_rd_d1       <= 1'b0;
            r_rd_d2       <= 1'b0;
            r_pid_d1      <= '0;
            r_pid_d2      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ram_address <= w_addr_nxt;
            r_ram_rden    <= w_rden_nxt;
            r_busy        <= w_busy_nxt;
            r_cell_count  <= w_count_nxt;
            r_done        <= w_done_nxt;
            r_next_addr   <= w_next_addr_nxt;
            r_rd_d1       <= r_ram_rden;
            r_rd_d2       <= r_rd_d1;
            r_pid_d1      <= r_ram_address;
            r_pid_d2      <= r_pid_d1;
            case ({r_ram_rden, r_rd_d2})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head       <= '0;
            r_head_valid <= 1'b0;
            r_head_last  <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_buf_count  <= '0;
        end else begin
            if (w_head_load) begin
                if (r_buf_count != '0) begin
                    r_head       <= r_buf[r_rd_ptr];
                    r_head_valid <= 1'b1;
                    r_head_last  <= (r_buf[r_rd_ptr].pid == r_cell_count);
                end else if (w_push) begin
                    r_head       <= '{pid: r_pid_d2, data: ram_q};
                    r_head_valid <= 1'b1;
                    r_head_last  <= (r_pid_d2 == r_cell_count);
                end else begin
                    r_head_valid <= 1'b0;
                end
            end
            if (w_buf_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_buf_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_buf_push, w_buf_pop})
                2'b10:   r_buf_count <= r_buf_count + 1'b1;
                2'b01:   r_buf_count <= r_buf_count - 1'b1;
                default: r_buf_count <= r_buf_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_push) r_buf[r_wr_ptr] <= '{pid: r_pid_d2, data: ram_q};
    end

    assign ram_address = r_ram_address;
    assign ram_rden    = r_ram_rden;
    assign ram_wren    = 1'b0;
    assign busy        = r_busy;
    assign cell_count  = r_cell_count;
    assign done        = r_done;
    assign out_valid   = r_head_valid;
    assign out_data    = r_head.data;
    assign out_pid     = r_head.pid;
    assign out_last    = r_head_last;

endmodule

// File: tb/tb_pos_cell_reader.sv
// Directed bench for pos_cell_reader with a 2-cycle-latency memory model and
// a negedge monitor that logs reads, beats, done pulses and busy edges.
module tb_pos_cell_reader;

    localparam int unsigned DW = 96;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          out_ready;
    logic [AW-1:0] ram_address;
    logic          ram_rden, ram_wren;
    logic [DW-1:0] ram_q;
    logic          busy;
    logic [AW-1:0] cell_count;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_pid;
    logic          out_last;
    logic          done;

    always #5 clk = ~clk;

    pos_cell_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(220), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ram_address(ram_address), .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q),
        .busy(busy), .cell_count(cell_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pid(out_pid), .out_last(out_last), .done(done)
    );

    // Memory: address registered, then data registered -> 2-cycle read latency.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] s1 = '0;
    logic [DW-1:0] q  = '0;
    always @(posedge clk) begin
        s1 <= mem[ram_address];
        q  <= s1;
    end
    assign ram_q = q;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            checks = 0;
    int            errors = 0;
    int            rd_addr_q[$], rd_cyc_q[$], beat_pid_q[$], beat_cyc_q[$], done_cyc_q[$];
    logic [DW-1:0] beat_data_q[$];
    bit            beat_last_q[$];
    int            busy_rise, busy_fall, stall_err, valid_seen, issued, accepted, max_occ, mon_rel;
    bit            prev_stall, mon_en;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_pid;

    function automatic logic [DW-1:0] pdat(input int k);
        return {32'(k * 7 + 1), 32'(k * 13 + 2), 32'(k ^ 32'h00A5_5A00)};
    endfunction

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            mon_rel = cyc - t0;
            if (ram_rden) begin
                rd_addr_q.push_back(int'(ram_address));
                rd_cyc_q.push_back(mon_rel);
                if (ram_address != '0) issued++;
            end
            if (issued - accepted > max_occ) max_occ = issued - accepted;
            if (prev_stall && !(out_valid && out_data === prev_data && out_pid === prev_pid)) stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_pid   = out_pid;
            if (out_valid) valid_seen++;
            if (out_valid && out_ready) begin
                beat_pid_q.push_back(int'(out_pid));
                beat_data_q.push_back(out_data);
                beat_last_q.push_back(out_last);
                beat_cyc_q.push_back(mon_rel);
                accepted++;
            end
            if (done) done_cyc_q.push_back(mon_rel);
            if (busy && busy_rise < 0) busy_rise = mon_rel;
            if (!busy && busy_rise >= 0 && busy_fall < 0) busy_fall = mon_rel;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_addr_q.delete(); rd_cyc_q.delete(); beat_pid_q.delete(); beat_cyc_q.delete();
        done_cyc_q.delete(); beat_data_q.delete(); beat_last_q.delete();
        busy_rise = -1; busy_fall = -1; stall_err = 0; valid_seen = 0;
        issued = 0; accepted = 0; max_occ = 0; prev_stall = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit bp);
        int n = 0;
        int r;
        while (done_cyc_q.size() == 0 && n < budget) begin
            @(posedge clk); #1;
            r = cyc - t0;
            out_ready = bp ? ((r % 5 == 0) || (r % 5 == 3)) : 1'b1;
            n++;
        end
        chk({tag, "_done_seen"}, 128'(done_cyc_q.size() > 0), 128'd1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_scan(input string tag, input int n);
        int bad = 0;
        chk({tag, "_nbeats"}, 128'(beat_pid_q.size()), 128'(n));
        for (int k = 0; k < beat_pid_q.size(); k++) begin
            if (beat_pid_q[k] != k + 1 || beat_data_q[k] !== pdat(k + 1) || beat_last_q[k] != (k + 1 == n))
                bad++;
        end
        chk({tag, "_beats"}, 128'(bad), 128'd0);
        chk({tag, "_done_cnt"}, 128'(done_cyc_q.size()), 128'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int exp_rc[4];
        for (int k = 0; k < 256; k++) mem[k] = pdat(k);
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; mon_en = 1'b0;
        clear_mon();
        mon_en = 1'b0;

        // Reset values, during and after reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 128'({ram_address, ram_rden, ram_wren, busy, cell_count, out_valid, out_pid, out_last, done}), 128'd0);
        chk("rst_data", 128'(out_data), 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ctrl", 128'({ram_address, ram_rden, ram_wren, busy, cell_count, out_valid, out_pid, out_last, done}), 128'd0);

        // Basic scan, count 3
        mem[0] = 96'd3;
        clear_mon();
        pulse_start();
        wait_done("basic", 100, 1'b0);
        check_scan("basic", 3);
        exp_rc = '{1, 4, 5, 6};
        chk("basic_nreads", 128'(rd_addr_q.size()), 128'd4);
        bad = 0;
        for (int i = 0; i < 4 && i < rd_addr_q.size(); i++)
            if (rd_addr_q[i] != i || rd_cyc_q[i] != exp_rc[i]) bad++;
        chk("basic_reads", 128'(bad), 128'd0);
        bad = 0;
        for (int i = 0; i < beat_cyc_q.size(); i++) if (beat_cyc_q[i] != 7 + i) bad++;
        chk("basic_beat_cycles", 128'(bad), 128'd0);
        chk("basic_done_cycle", 128'(done_cyc_q.size() > 0 ? done_cyc_q[0] : -1), 128'd10);
        chk("basic_busy_rise", 128'(busy_rise), 128'd1);
        chk("basic_busy_fall", 128'(busy_fall), 128'd11);
        chk("basic_cell_count", 128'(cell_count), 128'd3);
        chk("basic_wren", 128'(ram_wren), 128'd0);

        // Backpressure, count 5, ready 1,0,0,1,0 repeating
        mem[0] = 96'd5;
        clear_mon();
        pulse_start();
        wait_done("bp", 300, 1'b1);
        check_scan("bp", 5);
        chk("bp_stable", 128'(stall_err), 128'd0);
        chk("bp_occupancy", 128'(max_occ <= 4), 128'd1);
        chk("bp_nreads", 128'(rd_addr_q.size()), 128'd6);

        // Empty cell
        mem[0] = 96'd0;
        clear_mon();
        pulse_start();
        wait_done("empty", 100, 1'b0);
        chk("empty_valid", 128'(valid_seen), 128'd0);
        chk("empty_done_cnt", 128'(done_cyc_q.size()), 128'd1);
        chk("empty_done_cycle", 128'(done_cyc_q.size() > 0 ? done_cyc_q[0] : -1), 128'd4);
        chk("empty_busy_fall", 128'(busy_fall), 128'd5);
        chk("empty_reads", 128'({rd_addr_q.size() == 1, rd_addr_q.size() > 0 && rd_addr_q[0] == 0}), 128'd3);
        chk("empty_cell_count", 128'(cell_count), 128'd0);

        // Clamp: raw low byte 250 with upper junk -> 219
        mem[0] = 96'hDEAD_BEEF_1234_5678_0000_00FA;
        clear_mon();
        pulse_start();
        wait_done("clamp", 700, 1'b0);
        chk("clamp_cell_count", 128'(cell_count), 128'd219);
        check_scan("clamp", 219);
        chk("clamp_last", 128'(beat_pid_q.size() == 219 ? {beat_pid_q[218][7:0], beat_last_q[218]} : 9'd0), 128'h1B7);

        // Reset mid-scan of a 10-particle cell
        mem[0] = 96'd10;
        clear_mon();
        pulse_start();
        repeat (7) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ctrl", 128'({ram_address, ram_rden, busy, cell_count, out_valid, out_pid, out_last, done}), 128'd0);
        chk("rstmid_data", 128'(out_data), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        repeat (6) @(posedge clk);
        #1;
        chk("rstmid_quiet", 128'({valid_seen, 32'(rd_addr_q.size()), 32'(done_cyc_q.size())}), 128'd0);
        clear_mon();
        pulse_start();
        wait_done("rescan", 150, 1'b0);
        check_scan("rescan", 10);
        chk("rescan_first_beat", 128'(beat_cyc_q.size() > 0 ? beat_cyc_q[0] : -1), 128'd7);

        // Start re-pulsed during STREAM
        mem[0] = 96'd6;
        clear_mon();
        pulse_start();
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("sbusy", 150, 1'b0);
        check_scan("sbusy", 6);
        chk("sbusy_done_cycle", 128'(done_cyc_q.size() > 0 ? done_cyc_q[0] : -1), 128'd13);
        chk("sbusy_nreads", 128'(rd_addr_q.size()), 128'd7);
        chk("sbusy_idle", 128'(busy), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pos_cell_reader.md
# pos_cell_reader

Streaming read controller for one position cell memory (single-port, 2-cycle read latency, address 0 = particle count, addresses 1..N = `{posz, posy, posx}`). On a start pulse it reads the count word, then issues reads for particles 1..N. It returns them in order on a valid/ready stream toward the force-evaluation pipeline. A small internal skid FIFO absorbs the memory latency so downstream backpressure never drops data.

## Interface
- `DATA_WIDTH`, 96, width of one memory word, `{posz, posy, posx}` at 32 bits each.
- `ADDR_WIDTH`, 8, cell memory address width.
- `PARTICLE_NUM`, 220, memory depth. The maximum legal count is `PARTICLE_NUM-1`.
- `FIFO_DEPTH`, 4, skid FIFO entries. Must be ≥ 3.

- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a cell scan. Ignored while `busy`=1.
- `ram_address`  out  ADDR_WIDTH  registered read address to the cell memory.
- `ram_rden`  out  1  registered read enable.
- `ram_wren`  out  1  tied to 0. This block never writes.
- `ram_q`  in  DATA_WIDTH  memory read data, valid 2 cycles after the read is issued.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `cell_count`  out  ADDR_WIDTH  particle count captured from address 0, after clamping.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  DATA_WIDTH  particle position.
- `out_pid`  out  ADDR_WIDTH  particle address, 1..N.
- `out_last`  out  1  high with the beat carrying pid = N.
- `done`  out  1  one-cycle pulse when the scan completes.

## Operation
- **Reset.** All outputs are 0 during and after reset: `ram_address`, `ram_rden`, `busy`, `cell_count`, `out_*`, `done`. The FIFO is emptied and all counters are cleared. State goes to IDLE. Reset mid-scan discards all in-flight reads. Any `ram_q` arriving afterward is ignored.
- **FSM: IDLE → CNT_REQ → CNT_WAIT → STREAM → DRAIN → IDLE.**
  - **IDLE:** On `start`, go to CNT_REQ and set `busy`.
  - **CNT_REQ:** Drive `ram_rden`=1 with `ram_address`=0 for one cycle, then go to CNT_WAIT.
  - **CNT_WAIT:** Wait 2 cycles, then capture `ram_q[ADDR_WIDTH-1:0]` into `cell_count`.
    - Clamp: if the raw value is > `PARTICLE_NUM-1`, use `PARTICLE_NUM-1`.
    - Count 0: go straight to IDLE, pulsing `done` with no stream beats.
    - Otherwise go to STREAM with the next address = 1.
  - **STREAM:** Issue a read of the next address when `inflight + fifo_count + 1 ≤ FIFO_DEPTH`.
    - `inflight` counts reads issued but not yet returned (at most 2).
    - After issuing address = `cell_count`, go to DRAIN.
  - **DRAIN:** No new reads. When `inflight`=0, the FIFO is empty and the last beat has been accepted, pulse `done` and go to IDLE.
- **Return path.** Each returning word is written to the FIFO with its pid, delivered through a 2-stage pid delay line aligned to `ram_rden`. The credit rule guarantees the FIFO never overflows.
- **Stream.** The head of the FIFO drives `out_data`, `out_pid` and `out_last`. A beat transfers when `out_valid && out_ready`. `out_valid` stays high, with stable data, until the beat is accepted.
- **`out_last`** = (`out_pid` == `cell_count`).
- **`start` while busy:** ignored, with no effect on the current scan.
- **Simultaneous events.** FIFO push and pop in the same cycle leave `fifo_count` unchanged. A read issue and a return in the same cycle leave `inflight` unchanged.

## Timing
- `start` sampled high in cycle 0. Then:
  - `ram_rden`=1, `ram_address`=0 in cycle 1.
  - Count word on `ram_q` in cycle 3, captured at the end of cycle 3.
  - First particle read in cycle 4.
  - First `out_valid` in cycle 7 (FIFO registered output).
- With `out_ready` held at 1, the throughput is 1 beat/cycle.
  - Beat k (pid = k) has `out_valid` in cycle 6+k.
  - `done` pulses in the cycle after the last beat is accepted.
- Count 0: `done` pulses in cycle 4, and `busy` falls in cycle 5.
- The earliest restart is a `start` in the cycle after `done`.

## Test plan
- **Basic scan.** Count 3, particles A, B, C, `out_ready`=1 → beats (A,1), (B,2), (C,3,last) in cycles 7, 8, 9. `done` in cycle 10. Read addresses observed in order 0, 1, 2, 3.
- **Backpressure.** Count 5, with `out_ready` toggled 1,0,0,1,0 repeating → all 5 beats are delivered in order with no duplicates. Data is stable while stalled. At most `FIFO_DEPTH` reads are outstanding plus buffered at any time.
- **Empty cell.** Count 0 → no `out_valid`. `done` in cycle 4. Only address 0 is read.
- **Clamp.** Raw count 250 with `PARTICLE_NUM`=220 → `cell_count`=219. The last beat has pid 219 and `out_last`=1.
- **Reset mid-scan.** `rst` asserted during STREAM of a 10-particle cell → all outputs are 0 immediately. A new `start` then yields a clean scan starting at pid 1.
- **Start while busy.** `start` re-pulsed during STREAM → the current scan completes unchanged with a single `done`.
